// File: rtl/render_pkg.sv
// Shared types and defaults for the object renderer.
//   obj_t        one object-table slot {en, kind, x, y, w, h, rgb}
//   KIND_CIRCLE  x,y = centre, w = radius
//   KIND_RECT    x,y = top-left corner, w,h = extent (inclusive)
package render_pkg;

    localparam int unsigned OBJ_COORD_W = 10;

    localparam logic KIND_CIRCLE = 1'b0;
    localparam logic KIND_RECT   = 1'b1;

    localparam int unsigned H_OFF_DEF  = 144;
    localparam int unsigned V_OFF_DEF  = 35;
    localparam logic [23:0] BG_RGB_DEF = 24'h003232;

    typedef struct packed {
        logic                   en;
        logic                   kind;
        logic [OBJ_COORD_W-1:0] x;
        logic [OBJ_COORD_W-1:0] y;
        logic [OBJ_COORD_W-1:0] w;
        logic [OBJ_COORD_W-1:0] h;
        logic [23:0]            rgb;
    } obj_t;

endpackage

// File: rtl/obj_hit_test.sv
// Two-stage hit test for one object slot.
//   Stage 1 registers the signed offsets dx/dy of the pixel from the object
//   origin (blanking offsets folded in) together with the slot geometry.
//   Stage 2 registers the hit bit (circle or inclusive rectangle test).
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_pix_x, i_pix_y       raw VGA pixel coordinates
//   i_en, i_kind           slot enable, shape kind
//   i_obj_x, i_obj_y       object position (active-area coordinates)
//   i_w, i_h               radius or width / height
//   o_hit                  registered hit, two clocks after the pixel
module obj_hit_test
    import render_pkg::*;
#(
    parameter int unsigned COORD_W = OBJ_COORD_W,
    parameter int unsigned H_OFF   = H_OFF_DEF,
    parameter int unsigned V_OFF   = V_OFF_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [COORD_W-1:0] i_pix_x,
    input  logic [COORD_W-1:0] i_pix_y,
    input  logic               i_en,
    input  logic               i_kind,
    input  logic [COORD_W-1:0] i_obj_x,
    input  logic [COORD_W-1:0] i_obj_y,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    output logic               o_hit
);

    localparam int unsigned DW   = COORD_W + 2;
    localparam int unsigned SQ_W = 2 * COORD_W + 4;

    localparam logic [DW-1:0] H_OFF_W = DW'(H_OFF);
    localparam logic [DW-1:0] V_OFF_W = DW'(V_OFF);

    // Stage 1: two extra bits hold every possible difference without wrap.
    logic [DW-1:0]      w_dx, w_dy;
    logic [DW-1:0]      r_dx, r_dy;
    logic               r_en, r_kind;
    logic [COORD_W-1:0] r_w, r_h;

    assign w_dx = {2'b00, i_pix_x} - ({2'b00, i_obj_x} + H_OFF_W);
    assign w_dy = {2'b00, i_pix_y} - ({2'b00, i_obj_y} + V_OFF_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dx   <= '0;
            r_dy   <= '0;
            r_en   <= 1'b0;
            r_kind <= 1'b0;
            r_w    <= '0;
            r_h    <= '0;
        end else begin
            r_dx   <= w_dx;
            r_dy   <= w_dy;
            r_en   <= i_en;
            r_kind <= i_kind;
            r_w    <= i_w;
            r_h    <= i_h;
        end
    end

    // Stage 2: squares at full width so a radius above 2^(COORD_W/2) still works.
    logic signed [SQ_W-1:0] w_dx_s, w_dy_s, w_dx_sq, w_dy_sq;
    logic [SQ_W-1:0]        w_dist, w_r_ext, w_r_sq;
    logic                   w_circ, w_rect;

    assign w_dx_s  = {{(SQ_W-DW){r_dx[DW-1]}}, r_dx};
    assign w_dy_s  = {{(SQ_W-DW){r_dy[DW-1]}}, r_dy};
    assign w_dx_sq = w_dx_s * w_dx_s;
    assign w_dy_sq = w_dy_s * w_dy_s;
    assign w_dist  = $unsigned(w_dx_sq) + $unsigned(w_dy_sq);
    assign w_r_ext = {{(SQ_W-COORD_W){1'b0}}, r_w};
    assign w_r_sq  = w_r_ext * w_r_ext;
    assign w_circ  = (w_dist < w_r_sq);

    assign w_rect = ~r_dx[DW-1] & ~r_dy[DW-1] &
                    (r_dx <= {2'b00, r_w}) & (r_dy <= {2'b00, r_h});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit <= 1'b0;
        end else begin
            o_hit <= r_en & ((r_kind == KIND_RECT) ? w_rect : w_circ);
        end
    end

endmodule

// File: rtl/object_renderer.sv
// Per-pixel renderer for N_OBJ circles/rectangles with fixed 3-clock latency.
// Ports:
//   CLOCK_50, reset               clock, synchronous active-high reset
//   ativo, perdeu                 game state, delayed alongside the pixel
//   frame_start                   commits shadow table, publishes collisions
//   pix_valid, VGA_X, VGA_Y       raw pixel stream from VGA timing
//   obj_we, obj_addr, obj_*       shadow-table slot write
//   VGA_R/G/B, pix_valid_o        pixel colour, aligned with pix_valid_o
//   coll_vec, coll_stb            object-0 overlap vector of previous frame
module object_renderer
    import render_pkg::*;
#(
    parameter int unsigned N_OBJ   = 4,
    parameter int unsigned COORD_W = OBJ_COORD_W,  // must match obj_t field width
    parameter int unsigned H_OFF   = H_OFF_DEF,
    parameter int unsigned V_OFF   = V_OFF_DEF,
    parameter logic [23:0] BG_RGB  = BG_RGB_DEF,
    parameter int unsigned PIPE    = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     ativo,
    input  logic                     perdeu,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [COORD_W-1:0]       VGA_X,
    input  logic [COORD_W-1:0]       VGA_Y,
    input  logic                     obj_we,
    input  logic [$clog2(N_OBJ)-1:0] obj_addr,
    input  logic                     obj_en,
    input  logic                     obj_kind,
    input  logic [COORD_W-1:0]       obj_x,
    input  logic [COORD_W-1:0]       obj_y,
    input  logic [COORD_W-1:0]       obj_w,
    input  logic [COORD_W-1:0]       obj_h,
    input  logic [23:0]              obj_rgb,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     pix_valid_o,
    output logic [N_OBJ-1:0]         coll_vec,
    output logic                     coll_stb
);

    // Object table, double buffered.
    obj_t r_shadow [N_OBJ];
    obj_t r_active [N_OBJ];
    obj_t w_wr_obj;
    logic w_addr_ok;

    assign w_wr_obj  = '{en: obj_en, kind: obj_kind, x: obj_x, y: obj_y,
                         w: obj_w, h: obj_h, rgb: obj_rgb};
    assign w_addr_ok = (32'(obj_addr) < N_OBJ);

    // Active takes the pre-write shadow, so a write on the frame_start
    // cycle waits for the following frame.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                r_active <= r_shadow;
            end
            if (obj_we && w_addr_ok) begin
                r_shadow[obj_addr] <= w_wr_obj;
            end
        end
    end

    // Stages 1-2 per slot.
    logic [N_OBJ-1:0] w_hit;

    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
        obj_hit_test #(
            .COORD_W (COORD_W),
            .H_OFF   (H_OFF),
            .V_OFF   (V_OFF)
        ) u_hit (
            .i_clk   (CLOCK_50),
            .i_rst   (reset),
            .i_pix_x (VGA_X),
            .i_pix_y (VGA_Y),
            .i_en    (r_active[gi].en),
            .i_kind  (r_active[gi].kind),
            .i_obj_x (r_active[gi].x),
            .i_obj_y (r_active[gi].y),
            .i_w     (r_active[gi].w),
            .i_h     (r_active[gi].h),
            .o_hit   (w_hit[gi])
        );
    end

    // Side-band signals travel with the pixel; index PIPE-2 lines up with w_hit.
    logic [PIPE-1:0] r_vld;
    logic [PIPE-2:0] r_ativo, r_perdeu;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_vld    <= '0;
            r_ativo  <= '0;
            r_perdeu <= '0;
        end else begin
            r_vld    <= {r_vld[PIPE-2:0], pix_valid};
            r_ativo  <= {r_ativo[PIPE-3:0], ativo};
            r_perdeu <= {r_perdeu[PIPE-3:0], perdeu};
        end
    end

    // Stage 3: lowest index wins, so scan from the top down.
    logic [23:0] w_win_rgb;
    logic        w_live;
    logic [23:0] w_rgb_d;
    logic [23:0] r_rgb;

    always_comb begin
        w_win_rgb = BG_RGB;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win_rgb = r_active[i].rgb;
            end
        end
    end

    assign w_live  = r_vld[PIPE-2] & r_ativo[PIPE-2] & ~r_perdeu[PIPE-2];
    assign w_rgb_d = w_live ? w_win_rgb : 24'h000000;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb_d;
        end
    end

    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];
    assign pix_valid_o = r_vld[PIPE-1];

    // Collisions: a hit landing on the frame_start edge seeds the new frame.
    logic [N_OBJ-1:0] w_coll_hits;
    logic [N_OBJ-1:0] r_sticky, r_coll_vec;
    logic             r_coll_stb;

    assign w_coll_hits = (w_live & w_hit[0]) ? {w_hit[N_OBJ-1:1], 1'b0} : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sticky   <= '0;
            r_coll_vec <= '0;
            r_coll_stb <= 1'b0;
        end else begin
            r_coll_stb <= frame_start;
            if (frame_start) begin
                r_coll_vec <= r_sticky;
                r_sticky   <= w_coll_hits;
            end else begin
                r_sticky   <= r_sticky | w_coll_hits;
            end
        end
    end

    assign coll_vec = r_coll_vec;
    assign coll_stb = r_coll_stb;

endmodule

// File: tb/tb_object_renderer.sv
module tb_object_renderer;

    logic       clk = 1'b0;
    logic       reset, ativo, perdeu, frame_start, pix_valid;
    logic [9:0] VGA_X, VGA_Y;
    logic       obj_we, obj_en, obj_kind;
    logic [1:0] obj_addr;
    logic [9:0] obj_x, obj_y, obj_w, obj_h;
    logic [23:0] obj_rgb;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       pix_valid_o, coll_stb;
    logic [3:0] coll_vec;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [23:0] BG = 24'h003232;

    always #5 clk = ~clk;

    object_renderer dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .ativo       (ativo),
        .perdeu      (perdeu),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .obj_we      (obj_we),
        .obj_addr    (obj_addr),
        .obj_en      (obj_en),
        .obj_kind    (obj_kind),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_w       (obj_w),
        .obj_h       (obj_h),
        .obj_rgb     (obj_rgb),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .pix_valid_o (pix_valid_o),
        .coll_vec    (coll_vec),
        .coll_stb    (coll_stb)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        a;
        logic        p;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, VGA_R, VGA_G, VGA_B};
    endfunction

    task automatic wr(input int slot, input logic en, input logic kind, input int x, input int y,
                      input int w, input int h, input logic [23:0] rgb);
        obj_we   = 1'b1;
        obj_addr = 2'(slot);
        obj_en   = en;
        obj_kind = kind;
        obj_x    = 10'(x);
        obj_y    = 10'(y);
        obj_w    = 10'(w);
        obj_h    = 10'(h);
        obj_rgb  = rgb;
        step();
        obj_we   = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // One pixel through the pipe; checks latency, valid and colour.
    task automatic pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic a, input logic p, input logic [23:0] exp);
        VGA_X = x; VGA_Y = y; ativo = a; perdeu = p; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0; ativo = 1'b1; perdeu = 1'b0;
        step();
        check({name, " not_yet_valid"}, 32'(pix_valid_o), 32'd0);
        step();
        check({name, " valid"}, 32'(pix_valid_o), 32'd1);
        check({name, " rgb"}, rgb_now(), 32'(exp));
    endtask

    task automatic stream_overlap(input logic p);
        perdeu = p;
        for (int i = 0; i < 5; i++) begin
            VGA_X = 10'(344 + i); VGA_Y = 10'd235; pix_valid = 1'b1;
            step();
        end
        pix_valid = 1'b0; perdeu = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1; ativo = 1'b1; perdeu = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        VGA_X = '0; VGA_Y = '0; obj_we = 1'b0; obj_addr = '0; obj_en = 1'b0; obj_kind = 1'b0;
        obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_rgb = '0;
        repeat (3) step();
        check("reset rgb", rgb_now(), 32'd0);
        check("reset valid", 32'(pix_valid_o), 32'd0);
        check("reset coll_vec", 32'(coll_vec), 32'd0);
        check("reset coll_stb", 32'(coll_stb), 32'd0);
        reset = 1'b0;
        step();

        // Scene: circle r10, rect 20x10, circle r40, single-pixel rect.
        wr(0, 1'b1, 1'b0, 100, 100, 10, 0, 24'hFFFFFF);
        wr(1, 1'b1, 1'b1, 150, 50, 20, 10, 24'h00FF00);
        wr(2, 1'b1, 1'b0, 400, 300, 40, 0, 24'h0000FF);
        wr(3, 1'b1, 1'b1, 10, 10, 0, 0, 24'h123456);
        pixel("uncommitted", 10'd244, 10'd135, 1'b1, 1'b0, BG);
        frame();

        vecs[0]  = '{10'd244, 10'd135, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[1]  = '{10'd254, 10'd135, 1'b1, 1'b0, BG};
        vecs[2]  = '{10'd253, 10'd135, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[3]  = '{10'd244, 10'd125, 1'b1, 1'b0, BG};
        vecs[4]  = '{10'd244, 10'd126, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[5]  = '{10'd294, 10'd85,  1'b1, 1'b0, 24'h00FF00};
        vecs[6]  = '{10'd314, 10'd95,  1'b1, 1'b0, 24'h00FF00};
        vecs[7]  = '{10'd315, 10'd95,  1'b1, 1'b0, BG};
        vecs[8]  = '{10'd294, 10'd96,  1'b1, 1'b0, BG};
        vecs[9]  = '{10'd293, 10'd85,  1'b1, 1'b0, BG};
        vecs[10] = '{10'd574, 10'd355, 1'b1, 1'b0, 24'h0000FF};
        vecs[11] = '{10'd584, 10'd335, 1'b1, 1'b0, BG};
        vecs[12] = '{10'd154, 10'd45,  1'b1, 1'b0, 24'h123456};
        vecs[13] = '{10'd155, 10'd45,  1'b1, 1'b0, BG};
        vecs[14] = '{10'd154, 10'd46,  1'b1, 1'b0, BG};
        vecs[15] = '{10'd244, 10'd135, 1'b0, 1'b0, 24'h000000};
        vecs[16] = '{10'd244, 10'd135, 1'b1, 1'b1, 24'h000000};
        vecs[17] = '{10'd5,   10'd5,   1'b0, 1'b0, 24'h000000};

        for (int i = 0; i < 18; i++) begin
            pixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].p, vecs[i].rgb);
        end

        // Priority: circle slot0 and rect slot1 both cover (300,200).
        wr(0, 1'b1, 1'b0, 156, 165, 5, 0, 24'hAA0000);
        wr(1, 1'b1, 1'b1, 150, 160, 20, 20, 24'h00BB00);
        frame();
        pixel("prio slot0", 10'd300, 10'd200, 1'b1, 1'b0, 24'hAA0000);
        wr(0, 1'b0, 1'b0, 156, 165, 5, 0, 24'hAA0000);
        frame();
        pixel("prio slot1", 10'd300, 10'd200, 1'b1, 1'b0, 24'h00BB00);

        // Mid-frame write stays hidden until frame_start.
        wr(1, 1'b1, 1'b1, 0, 0, 1, 1, 24'h00CC00);
        pixel("midframe old", 10'd300, 10'd200, 1'b1, 1'b0, 24'h00BB00);
        frame();
        pixel("newframe old gone", 10'd300, 10'd200, 1'b1, 1'b0, BG);
        pixel("newframe new", 10'd144, 10'd35, 1'b1, 1'b0, 24'h00CC00);
        obj_we = 1'b1; obj_addr = 2'd1; obj_en = 1'b1; obj_kind = 1'b1;
        obj_x = 10'd0; obj_y = 10'd0; obj_w = 10'd1; obj_h = 10'd1; obj_rgb = 24'h00DD00;
        frame();
        obj_we = 1'b0;
        pixel("fs write deferred", 10'd144, 10'd35, 1'b1, 1'b0, 24'h00CC00);
        frame();
        pixel("fs write landed", 10'd144, 10'd35, 1'b1, 1'b0, 24'h00DD00);

        // Collisions: slots 0 and 2 share a 5-pixel row.
        wr(0, 1'b1, 1'b1, 200, 200, 4, 0, 24'h111111);
        wr(2, 1'b1, 1'b1, 200, 200, 4, 0, 24'h222222);
        wr(1, 1'b0, 1'b0, 0, 0, 0, 0, 24'h0);
        wr(3, 1'b0, 1'b0, 0, 0, 0, 0, 24'h0);
        frame();
        frame();
        check("coll empty vec", 32'(coll_vec), 32'd0);
        check("coll empty stb", 32'(coll_stb), 32'd1);
        step();
        stream_overlap(1'b0);
        check("coll stb idle", 32'(coll_stb), 32'd0);
        frame();
        check("coll vec", 32'(coll_vec), 32'b0100);
        check("coll stb", 32'(coll_stb), 32'd1);
        step();
        check("coll stb one clk", 32'(coll_stb), 32'd0);
        check("coll vec held", 32'(coll_vec), 32'b0100);
        frame();
        check("coll cleared", 32'(coll_vec), 32'd0);
        stream_overlap(1'b1);
        frame();
        check("coll perdeu ignored", 32'(coll_vec), 32'd0);

        // Hit reaching stage 3 on the frame_start edge belongs to the new frame.
        VGA_X = 10'd346; VGA_Y = 10'd235; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
        frame();
        check("coll edge old frame", 32'(coll_vec), 32'd0);
        repeat (2) step();
        frame();
        check("coll edge new frame", 32'(coll_vec), 32'b0100);

        // Reset mid-stream.
        VGA_X = 10'd344; VGA_Y = 10'd235; pix_valid = 1'b1; ativo = 1'b1;
        repeat (3) step();
        check("pre-reset rgb", rgb_now(), 32'h111111);
        reset = 1'b1;
        step();
        check("reset mid rgb", rgb_now(), 32'd0);
        check("reset mid valid", 32'(pix_valid_o), 32'd0);
        check("reset mid coll_vec", 32'(coll_vec), 32'd0);
        reset = 1'b0;
        step();
        check("release valid 1", 32'(pix_valid_o), 32'd0);
        step();
        check("release valid 2", 32'(pix_valid_o), 32'd0);
        step();
        check("release valid 3", 32'(pix_valid_o), 32'd1);
        check("release table cleared", rgb_now(), 32'(BG));
        pix_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
